sm3_add3_arb: RTL and testbench
===============================

# sm3_add3_arb

Round-robin arbiter and result register for one shared 3-input, 32-bit modulo-2^32 adder in the SM3 core. NUM_REQ requesters use it: message expansion, the TT1/TT2 round terms and the final V-update. Each accepted request returns (A + B + C) mod 2^32, tagged with the requester index, one cycle later through a single-entry output register with valid/ready backpressure. A saturating grant counter per requester supports performance checks.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- ID_W, default $clog2(NUM_REQ): width of the requester tag.
- CNT_W, default 16: width of each per-requester grant counter.

- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  NUM_REQ  request pending, one bit per requester.
- req_ready_o  out  NUM_REQ  one-hot grant/accept; a transfer happens when valid[i] && ready[i].
- req_a_i, req_b_i, req_c_i  in  NUM_REQ*32 each  operands, requester i in bits [32i+31:32i].
- rsp_valid_o  out  1  result register holds a result.
- rsp_ready_i  in  1  consumer accepts the result.
- rsp_data_o  out  32  (A + B + C) mod 2^32.
- rsp_id_o  out  ID_W  index of the requester that produced rsp_data_o.
- grant_cnt_o  out  NUM_REQ*CNT_W  per-requester accepted-request count, saturating.
- clr_cnt_i  in  1  synchronous clear of all grant counters.

## Operation
- Adder: carry-save compress to S = A^B^C and Ca = maj(A,B,C), then sum = {Ca[30:0],1'b0} + S. Keep the low 32 bits. No carry-out.
- can_accept = !rsp_valid_o || rsp_ready_i, so a result can be drained and a new request loaded in the same cycle.
- Round-robin pointer ptr (ID_W bits), reset 0.
  - The grant goes to the first i with req_valid_i[i] = 1, searching ptr, ptr+1, … mod NUM_REQ.
  - req_ready_o is one-hot on that index when can_accept = 1, otherwise all zero.
  - req_ready_o depends only on req_valid_i, ptr and state; it never depends on operand values.
- On a transfer from index g:
  - The result register loads the sum and rsp_id_o = g.
  - rsp_valid_o is set to 1.
  - ptr becomes (g+1) mod NUM_REQ.
  - grant_cnt[g] increments, holding at 2^CNT_W-1.
- Without a transfer, ptr holds.
- On a drain (rsp_valid_o && rsp_ready_i) with no transfer in the same cycle, rsp_valid_o goes to 0. rsp_data_o and rsp_id_o keep their last values.
- While rsp_valid_o = 1 and rsp_ready_i = 0, rsp_data_o and rsp_id_o stay stable.
- Requesters must hold valid and operands stable until accepted. The arbiter does not latch pending requests.
- clr_cnt_i clears all counters. If a grant happens in the same cycle, clear wins: the counter ends at 0.
- A requester that drops valid before acceptance is simply skipped. No error is raised.

## Timing
- Reset values: rsp_valid_o = 0, rsp_data_o = 0, rsp_id_o = 0, ptr = 0, all grant_cnt = 0. req_ready_o equals the combinational grant, since can_accept = 1 after reset.
- Latency is 1 cycle: a transfer on edge n gives rsp_valid_o = 1 with the result after edge n.
- Sustained throughput is 1 result per cycle while rsp_ready_i = 1.
- Fairness: with all NUM_REQ requesters continuously valid and no backpressure, each is granted exactly once in every NUM_REQ consecutive grants.
- rst_i asserted mid-operation discards the in-flight result and returns everything to reset values on the next edge. req_ready_o is held at 0 during the reset cycle.
- The grant path (req_valid_i to req_ready_o) is combinational. There is no combinational path from operands to outputs.

## Test plan
- Wrap-around arithmetic: requester 0 sends A = 0xFFFFFFFF, B = 0x00000001, C = 0x00000001. Expect rsp_data_o = 0x00000001 and rsp_id_o = 0 one cycle later. A second request 0x80000000 ×3 gives 0x80000000.
- Round-robin: all 4 requesters valid, rsp_ready_i = 1. Grant order is 0,1,2,3,0,1,… and each grant_cnt reads 2 after 8 cycles.
- Backpressure: load a result, then hold rsp_ready_i = 0 for 5 cycles while requester 2 stays valid. req_ready_o stays 0 and rsp_data_o stays stable. Raising rsp_ready_i drains the result and accepts requester 2 in the same cycle.
- Pointer skip: after granting requester 1, only requesters 0 and 3 are valid. Requester 3 is granted next, then requester 0.
- Counter saturation and clear: with CNT_W = 4, 20 grants to requester 1 leave its counter at 15. clr_cnt_i pulsed together with a grant leaves it at 0.
- Reset mid-stream: assert rst_i while rsp_valid_o = 1. After the edge, rsp_valid_o = 0, ptr = 0, all counters = 0, and the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/sm3_add3_arb.sv
// Round-robin arbiter in front of one shared 3-input modulo-2^32 adder.
// The result goes to a single-entry output register with valid/ready backpressure.
module sm3_add3_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*32-1:0]    req_a_i,
  input  logic [NUM_REQ*32-1:0]    req_b_i,
  input  logic [NUM_REQ*32-1:0]    req_c_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_data_o,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [NUM_REQ*CNT_W-1:0] grant_cnt_o,
  input  logic                     clr_cnt_i
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(NUM_REQ - 1);

  // Carry-save compress three operands to sum and carry, then one carry-propagate add.
  function automatic logic [31:0] add3_csa(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] c);
    logic [31:0] s;
    logic [31:0] ca;
    s  = a ^ b ^ c;
    ca = (a & b) | (a & c) | (b & c);
    return {ca[30:0], 1'b0} + s;
  endfunction

  logic                            rsp_valid_q, rsp_valid_d;
  logic [31:0]                     rsp_data_q,  rsp_data_d;
  logic [ID_W-1:0]                 rsp_id_q,    rsp_id_d;
  logic [ID_W-1:0]                 ptr_q,       ptr_d;
  logic [NUM_REQ-1:0][CNT_W-1:0]   cnt_q,       cnt_d;

  logic                            can_accept;
  logic                            found;
  logic [ID_W-1:0]                 gnt_idx;
  logic [NUM_REQ-1:0]              ready;
  logic                            xfer;
  logic [31:0]                     sum;

  // Rotating priority search starting at ptr; depends only on valids and state.
  always_comb begin
    int idx;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found   = 1'b1;
        gnt_idx = idx[ID_W-1:0];
      end else begin
        found   = found;
      end
    end
  end

  // Grant decode and next-state computation for result register, pointer and counters.
  always_comb begin
    can_accept  = !rsp_valid_q || rsp_ready_i;
    ready       = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    sum         = add3_csa(req_a_i[32*gnt_idx +: 32],
                           req_b_i[32*gnt_idx +: 32],
                           req_c_i[32*gnt_idx +: 32]);

    if (found && can_accept && !rst_i) begin
      ready[gnt_idx] = 1'b1;
    end else begin
      ready = '0;
    end
    xfer = |ready;

    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = sum;
      rsp_id_d    = gnt_idx;
      ptr_d       = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + ID_W'(1);
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end

    // Clear takes priority over a same-cycle increment.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (clr_cnt_i) begin
        cnt_d[i] = '0;
      end else if (xfer && (gnt_idx == ID_W'(i)) && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0000_0000;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready_o = ready;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;
  assign grant_cnt_o = cnt_q;

endmodule

// File: tb/tb_sm3_add3_arb.sv
// Scoreboard bench for sm3_add3_arb: a reference model predicts grants and results,
// and a monitor compares every presented result against the expected queue.
module tb_sm3_add3_arb;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int CW  = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [N-1:0]      req_valid_i;
  logic [N-1:0]      req_ready_o;
  logic [N*32-1:0]   req_a_i, req_b_i, req_c_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [31:0]       rsp_data_o;
  logic [IDW-1:0]    rsp_id_o;
  logic [N*CW-1:0]   grant_cnt_o;
  logic              clr_cnt_i;

  always #5 clk = ~clk;

  sm3_add3_arb #(.NUM_REQ(N), .ID_W(IDW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_c_i(req_c_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o),
    .grant_cnt_o(grant_cnt_o), .clr_cnt_i(clr_cnt_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  int m_ptr;
  bit m_valid;
  int m_cnt[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    req_a_i[i*32 +: 32] = a;
    req_b_i[i*32 +: 32] = b;
    req_c_i[i*32 +: 32] = c;
  endtask

  // Reference model: evaluated mid-cycle, predicts the next edge.
  initial begin
    m_ptr   = 0;
    m_valid = 1'b0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #3;
      if (rst_i) begin
        chk("ready_in_reset", req_ready_o, 0);
        m_ptr   = 0;
        m_valid = 1'b0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        exp_q.delete();
      end else begin
        logic [N*CW-1:0] ecnt;
        logic [N-1:0]    eready;
        int              g;
        for (int i = 0; i < N; i++) ecnt[i*CW +: CW] = m_cnt[i][CW-1:0];
        chk("rsp_valid", rsp_valid_o, m_valid);
        chk("grant_cnt", grant_cnt_o, ecnt);
        g = -1;
        if (!m_valid || rsp_ready_i) begin
          for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid_i[(m_ptr + k) % N]) g = (m_ptr + k) % N;
          end
        end
        eready = '0;
        if (g >= 0) eready[g] = 1'b1;
        chk("req_ready", req_ready_o, eready);
        if (g >= 0) begin
          rsp_t r;
          r.id   = g;
          r.data = req_a_i[g*32 +: 32] + req_b_i[g*32 +: 32] + req_c_i[g*32 +: 32];
          exp_q.push_back(r);
          m_ptr = (g + 1) % N;
        end
        if (clr_cnt_i) begin
          foreach (m_cnt[i]) m_cnt[i] = 0;
        end else if (g >= 0 && m_cnt[g] < (1 << CW) - 1) begin
          m_cnt[g]++;
        end
        if (g >= 0) m_valid = 1'b1;
        else if (m_valid && rsp_ready_i) m_valid = 1'b0;
      end
    end
  end

  // Monitor: every presented result must match the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i && rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          chk("rsp_data", rsp_data_o, exp_q[0].data);
          chk("rsp_id", rsp_id_o, exp_q[0].id);
          if (rsp_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_i       = 1'b1;
    req_valid_i = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    req_c_i     = '0;
    rsp_ready_i = 1'b1;
    clr_cnt_i   = 1'b0;
    step();
    req_valid_i = 4'b0110;
    #1;
    chk("reset_valid", rsp_valid_o, 0);
    chk("reset_data", rsp_data_o, 0);
    chk("reset_id", rsp_id_o, 0);
    chk("reset_cnt", grant_cnt_o, 0);
    chk("reset_ready_held", req_ready_o, 0);
    step();
    rst_i       = 1'b0;
    req_valid_i = '0;
    step();

    // Wrap-around arithmetic on requester 0.
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    req_valid_i = 4'b0001;
    step();
    set_op(0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    #1;
    chk("wrap_data", rsp_data_o, 32'h0000_0001);
    chk("wrap_id", rsp_id_o, 0);
    step();
    req_valid_i = '0;
    #1;
    chk("msb_data", rsp_data_o, 32'h8000_0000);
    step();

    // Round-robin with everybody valid.
    clr_cnt_i = 1'b1;
    step();
    clr_cnt_i = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom, $urandom);
    req_valid_i = 4'b1111;
    repeat (8) step();
    req_valid_i = '0;
    #1;
    for (int i = 0; i < N; i++) chk("rr_cnt", grant_cnt_o[i*CW +: CW], 2);

    // Backpressure while requester 2 waits.
    set_op(0, 32'd1, 32'd2, 32'd3);
    set_op(2, 32'd10, 32'd20, 32'd30);
    req_valid_i = 4'b0001;
    step();
    req_valid_i = 4'b0100;
    rsp_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready", req_ready_o, 0);
      chk("bp_data", rsp_data_o, 32'd6);
      step();
    end
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_accept", req_ready_o, 4'b0100);
    step();
    req_valid_i = '0;
    #1;
    chk("bp_id", rsp_id_o, 2);
    chk("bp_sum", rsp_data_o, 32'd60);

    // Pointer skip after granting requester 1.
    req_valid_i = 4'b0010;
    step();
    req_valid_i = 4'b1001;
    #1;
    chk("skip_3", req_ready_o, 4'b1000);
    step();
    #1;
    chk("skip_0", req_ready_o, 4'b0001);
    step();
    req_valid_i = '0;

    // Counter saturation and clear-wins.
    req_valid_i = 4'b0010;
    repeat (20) step();
    req_valid_i = '0;
    #1;
    chk("sat_cnt", grant_cnt_o[CW +: CW], 15);
    req_valid_i = 4'b0010;
    clr_cnt_i   = 1'b1;
    step();
    req_valid_i = '0;
    clr_cnt_i   = 1'b0;
    #1;
    chk("clr_cnt", grant_cnt_o[CW +: CW], 0);
    chk("clr_grant_id", rsp_id_o, 1);

    // Reset mid-stream with a result held.
    req_valid_i = 4'b0001;
    step();
    req_valid_i = '0;
    rsp_ready_i = 1'b0;
    #1;
    chk("pre_rst_valid", rsp_valid_o, 1);
    rst_i = 1'b1;
    step();
    rst_i       = 1'b0;
    rsp_ready_i = 1'b1;
    req_valid_i = 4'b1010;
    #1;
    chk("rst_valid", rsp_valid_o, 0);
    chk("rst_data", rsp_data_o, 0);
    chk("rst_cnt", grant_cnt_o, 0);
    chk("rst_lowest", req_ready_o, 4'b0010);
    step();
    req_valid_i = '0;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rst_i       = ($urandom_range(99) == 0);
      clr_cnt_i   = ($urandom_range(39) == 0);
      rsp_ready_i = ($urandom_range(3) != 0);
      req_valid_i = N'($urandom);
      for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom, $urandom);
      step();
    end
    rst_i       = 1'b0;
    clr_cnt_i   = 1'b0;
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    repeat (3) step();
    chk("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
